// File: rtl/iq_pkg.sv
// Shared constants, state encoding and quantizer for the IQ sample path.
// read_iq and write_iq both use these widths so the two directions stay in step.
package iq_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned QUANT_BITS   = 10;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_e;

    // Arithmetic shift (rounds toward -inf), then clamp to the signed 16-bit range.
    function automatic logic [SAMPLE_WIDTH-1:0] quantize_sat(input logic [DATA_WIDTH-1:0] sample);
        logic signed [DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-SAMPLE_WIDTH:0] upper;
        shifted = $signed(sample) >>> QUANT_BITS;
        upper   = shifted[DATA_WIDTH-1:SAMPLE_WIDTH-1];
        if (upper == '0 || upper == '1) begin
            return shifted[SAMPLE_WIDTH-1:0];
        end else if (shifted[DATA_WIDTH-1]) begin
            return {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/iq_quantize_sat.sv
// Combinational quantizer: arithmetic right shift followed by saturation to SAMPLE_WIDTH bits.
module iq_quantize_sat #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned QUANT_BITS   = 10
) (
    input  logic [DATA_WIDTH-1:0]   sample,
    output logic [SAMPLE_WIDTH-1:0] quant
);

    logic signed [DATA_WIDTH-1:0]     shifted;
    logic        [DATA_WIDTH-SAMPLE_WIDTH:0] upper;

    always_comb begin
        shifted = $signed(sample) >>> QUANT_BITS;
        // The value fits when every bit from the sign down to the new sign bit agrees.
        upper   = shifted[DATA_WIDTH-1:SAMPLE_WIDTH-1];
        if (upper == '0 || upper == '1) begin
            quant = shifted[SAMPLE_WIDTH-1:0];
        end else if (shifted[DATA_WIDTH-1]) begin
            quant = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        end else begin
            quant = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/write_iq.sv
// Output-side IQ packer: pops an I/Q pair, quantizes both to 16 bits and pushes
// {Q16, I16} into the output FIFO through a one-word hold register.
module write_iq #(
    parameter int unsigned DATA_WIDTH   = iq_pkg::DATA_WIDTH,
    parameter int unsigned SAMPLE_WIDTH = iq_pkg::SAMPLE_WIDTH,
    parameter int unsigned QUANT_BITS   = iq_pkg::QUANT_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  inI_rd_en,
    input  logic                  inI_empty,
    input  logic [DATA_WIDTH-1:0] inI_dout,
    output logic                  inQ_rd_en,
    input  logic                  inQ_empty,
    input  logic [DATA_WIDTH-1:0] inQ_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din
);

    import iq_pkg::*;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [SAMPLE_WIDTH-1:0] i_quant, q_quant;
    logic [DATA_WIDTH-1:0]   packed_word;
    logic                    pop;

    iq_quantize_sat #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .QUANT_BITS  (QUANT_BITS)
    ) u_quant_i (
        .sample(inI_dout),
        .quant (i_quant)
    );

    iq_quantize_sat #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .QUANT_BITS  (QUANT_BITS)
    ) u_quant_q (
        .sample(inQ_dout),
        .quant (q_quant)
    );

    assign packed_word = DATA_WIDTH'({q_quant, i_quant});

    always_comb begin
        // Gated by reset so nothing is popped while the block is held in reset.
        pop = reset && !inI_empty && !inQ_empty &&
              (state_q == S_IDLE || (state_q == S_HOLD && !out_full));

        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    hold_d  = packed_word;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!out_full) begin
                    if (pop) begin
                        hold_d = packed_word;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        inI_rd_en = pop;
        inQ_rd_en = pop;
        out_wr_en = (state_q == S_HOLD) && !out_full;
        out_din   = (state_q == S_HOLD) ? hold_q : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_write_iq.sv
// Bench for write_iq: show-ahead FIFO models on the inputs, a scoreboard of popped
// pairs checked against every push, and directed scenarios with literal expectations.
module tb_write_iq;

    logic        clock;
    logic        reset;
    logic        inI_rd_en, inQ_rd_en;
    logic        inI_empty, inQ_empty;
    logic [31:0] inI_dout, inQ_dout;
    logic        out_wr_en;
    logic        out_full;
    logic [31:0] out_din;

    write_iq dut (
        .clock    (clock),
        .reset    (reset),
        .inI_rd_en(inI_rd_en),
        .inI_empty(inI_empty),
        .inI_dout (inI_dout),
        .inQ_rd_en(inQ_rd_en),
        .inQ_empty(inQ_empty),
        .inQ_dout (inQ_dout),
        .out_wr_en(out_wr_en),
        .out_full (out_full),
        .out_din  (out_din)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int first_pop = -1;
    bit pop_flag = 1'b0;

    logic [31:0] qi[$];
    logic [31:0] qq[$];
    logic [31:0] pend[$];
    logic [31:0] push_log[$];
    int          push_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] q16(input logic [31:0] s);
        int v;
        v = $signed(s);
        v = v >>> 10;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] i, input logic [31:0] q);
        return {q16(q), q16(i)};
    endfunction

    // Input FIFO model: pops land just after the edge the DUT popped on.
    always @(posedge clock) begin
        #1;
        if (pop_flag) begin
            if (qi.size() > 0) void'(qi.pop_front());
            if (qq.size() > 0) void'(qq.pop_front());
            pop_flag = 1'b0;
        end
        inI_empty = (qi.size() == 0);
        inQ_empty = (qq.size() == 0);
        inI_dout  = (qi.size() > 0) ? qi[0] : 32'h0;
        inQ_dout  = (qq.size() > 0) ? qq[0] : 32'h0;
    end

    // Compare process: at most one word is outstanding between pop and push.
    always @(negedge clock) begin
        bit          exp_rd, exp_wr;
        logic [31:0] exp_din;
        cyc++;
        if (reset) begin
            exp_rd  = !inI_empty && !inQ_empty && (pend.size() == 0 || !out_full);
            exp_wr  = (pend.size() != 0) && !out_full;
            exp_din = (pend.size() != 0) ? pend[0] : 32'h0;
            check("rd_en_i", {31'b0, inI_rd_en}, {31'b0, exp_rd});
            check("rd_en_q", {31'b0, inQ_rd_en}, {31'b0, exp_rd});
            check("wr_en", {31'b0, out_wr_en}, {31'b0, exp_wr});
            check("out_din", out_din, exp_din);
            if (out_wr_en) begin
                push_log.push_back(out_din);
                push_cyc.push_back(cyc);
            end
            if (exp_wr) void'(pend.pop_front());
            if (exp_rd) begin
                pend.push_back(golden(inI_dout, inQ_dout));
                pop_flag = 1'b1;
                if (first_pop < 0) first_pop = cyc;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic push_pair(input logic [31:0] i, input logic [31:0] q);
        qi.push_back(i);
        qq.push_back(q);
    endtask

    initial begin
        int          base;
        int          gaps;
        logic [31:0] held;

        reset     = 1'b0;
        out_full  = 1'b0;
        inI_empty = 1'b1;
        inQ_empty = 1'b1;
        inI_dout  = 32'h0;
        inQ_dout  = 32'h0;

        check("model_pin_basic", golden(32'd1024, -32'sd1024), 32'hFFFF_0001);
        check("model_pin_round", golden(-32'sd1, 32'd1023), 32'h0000_FFFF);

        // Reset holds everything quiet even with a pair waiting.
        push_pair(32'd1024, -32'sd1024);
        wait_cyc(2);
        check("reset_rd_en", {31'b0, inI_rd_en}, 32'h0);
        check("reset_wr_en", {31'b0, out_wr_en}, 32'h0);
        check("reset_din", out_din, 32'h0);
        reset = 1'b1;
        wait_cyc(4);
        check("basic_count", push_log.size(), 1);
        if (push_log.size() >= 1) begin
            check("basic_word", push_log[0], 32'hFFFF_0001);
            check("basic_latency", push_cyc[0], first_pop + 1);
        end

        // Saturation and rounding toward -inf.
        base = push_log.size();
        push_pair(32'h7FFF_FFFF, 32'h8000_0000);
        push_pair(32'hFFFF_FFFF, 32'd1023);
        wait_cyc(5);
        check("satround_count", push_log.size(), base + 2);
        if (push_log.size() >= base + 2) begin
            check("sat_word", push_log[base], 32'h8000_7FFF);
            check("round_word", push_log[base+1], 32'h0000_FFFF);
        end

        // Streaming without backpressure: one push per cycle.
        base = push_log.size();
        for (int k = 0; k < 256; k++) push_pair($urandom, $urandom);
        wait_cyc(262);
        check("stream_count", push_log.size(), base + 256);
        gaps = 0;
        for (int k = base + 1; k < push_log.size(); k++) begin
            if (push_cyc[k] != push_cyc[k-1] + 1) gaps++;
        end
        check("stream_gaps", gaps, 0);

        // Backpressure mid-stream.
        base = push_log.size();
        for (int k = 0; k < 20; k++) push_pair(32'(k * 1024 + 7), 32'(-k * 2048));
        wait_cyc(6);
        out_full = 1'b1;
        wait_cyc(1);
        held = out_din;
        gaps = push_log.size();
        for (int k = 0; k < 4; k++) begin
            wait_cyc(1);
            check("stall_din", out_din, held);
            check("stall_rd_en", {31'b0, inI_rd_en}, 32'h0);
        end
        check("stall_no_push", push_log.size(), gaps);
        out_full = 1'b0;
        wait_cyc(25);
        check("bp_count", push_log.size(), base + 20);
        check("bp_drained", pend.size(), 0);

        // Q starved while I holds three samples.
        base = push_log.size();
        qi.push_back(32'd2048);
        qi.push_back(32'd4096);
        qi.push_back(32'd8192);
        wait_cyc(5);
        check("starve_no_push", push_log.size(), base);
        check("starve_i_kept", qi.size(), 3);
        for (int k = 0; k < 3; k++) qq.push_back(32'd0);
        wait_cyc(6);
        check("starve_count", push_log.size(), base + 3);
        if (push_log.size() >= base + 3) begin
            check("starve_w0", push_log[base], 32'h0000_0002);
            check("starve_w1", push_log[base+1], 32'h0000_0004);
            check("starve_w2", push_log[base+2], 32'h0000_0008);
        end

        // Async reset while a word is held against a full output.
        out_full = 1'b1;
        push_pair(32'd3072, 32'd0);
        wait_cyc(4);
        check("held_din", out_din, 32'h0000_0003);
        reset = 1'b0;
        #1;
        check("arst_wr_en", {31'b0, out_wr_en}, 32'h0);
        check("arst_din", out_din, 32'h0);
        pend.delete();
        pop_flag = 1'b0;
        out_full = 1'b0;
        wait_cyc(2);
        base = push_log.size();
        reset = 1'b1;
        push_pair(-32'sd2048, 32'd4096);
        wait_cyc(5);
        check("post_rst_count", push_log.size(), base + 1);
        if (push_log.size() >= base + 1) begin
            check("post_rst_word", push_log[base], 32'h0004_FFFE);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
